// File: rtl/hdlc_tx_sequencer.sv
// HDLC transmit sequencer: start flag, LSB-first payload with zero insertion,
// end flag, and a 0-then-seven-1s abort pattern. All outputs are registered.
module hdlc_tx_sequencer #(
  parameter int MAX_BYTES = 128
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tx_Enable,
  input  logic       Tx_AbortFrame,
  input  logic [7:0] Tx_FrameSize,
  input  logic [7:0] Tx_Data,
  output logic       Tx_RdBuff,
  output logic       Tx,
  output logic       Tx_ValidFrame,
  output logic       Tx_AbortedTrans,
  output logic       Tx_Done,
  output logic       Tx_SizeErr,
  output logic [2:0] DbgState
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_FLAG = 3'd1,
    DATA       = 3'd2,
    END_FLAG   = 3'd3,
    ABORT      = 3'd4
  } state_t;

  localparam logic [7:0] FLAG = 8'h7E;
  localparam logic [8:0] MAX_SIZE = 9'(MAX_BYTES);

  state_t     state;
  logic [3:0] bitCnt;
  logic [7:0] shiftReg;
  logic [7:0] holdReg;
  logic [2:0] bitsLeft;
  logic [2:0] onesCnt;
  logic [7:0] byteCnt;
  logic       fetchPend;
  logic       sizeOk;
  logic [7:0] loadByte;

  // Buffer read: a Tx_RdBuff pulse in cycle c means Tx_Data is valid in c+1
  // only; fetchPend marks that cycle so the byte is captured (or, for byte 0,
  // loaded straight into the shifter at the end of the start flag).
  assign sizeOk   = (Tx_FrameSize != 8'd0) && ({1'b0, Tx_FrameSize} <= MAX_SIZE);
  assign loadByte = fetchPend ? Tx_Data : holdReg;
  assign DbgState = state;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state           <= IDLE;
      bitCnt          <= 4'd0;
      shiftReg        <= 8'd0;
      holdReg         <= 8'd0;
      bitsLeft        <= 3'd0;
      onesCnt         <= 3'd0;
      byteCnt         <= 8'd0;
      fetchPend       <= 1'b0;
      Tx              <= 1'b1;
      Tx_ValidFrame   <= 1'b0;
      Tx_AbortedTrans <= 1'b0;
      Tx_Done         <= 1'b0;
      Tx_RdBuff       <= 1'b0;
      Tx_SizeErr      <= 1'b0;
    end else begin
      Tx_Done    <= 1'b0;
      Tx_SizeErr <= 1'b0;
      Tx_RdBuff  <= 1'b0;
      fetchPend  <= Tx_RdBuff;
      if (fetchPend) holdReg <= Tx_Data;

      case (state)
        IDLE: begin
          Tx            <= 1'b1;
          Tx_ValidFrame <= 1'b0;
          if (Tx_Enable) begin
            if (sizeOk) begin
              state           <= START_FLAG;
              Tx              <= FLAG[0];
              Tx_ValidFrame   <= 1'b1;
              Tx_AbortedTrans <= 1'b0;
              bitCnt          <= 4'd1;
              byteCnt         <= Tx_FrameSize;
              onesCnt         <= 3'd0;
            end else begin
              Tx_SizeErr <= 1'b1;
            end
          end
        end

        START_FLAG: begin
          if (Tx_AbortFrame) begin
            state           <= ABORT;
            Tx              <= 1'b0;
            Tx_ValidFrame   <= 1'b0;
            Tx_AbortedTrans <= 1'b1;
            bitCnt          <= 4'd1;
          end else if (bitCnt == 4'd8) begin
            state     <= DATA;
            Tx        <= loadByte[0];
            shiftReg  <= loadByte >> 1;
            bitsLeft  <= 3'd7;
            onesCnt   <= {2'b00, loadByte[0]};
            byteCnt   <= (byteCnt != 8'd0) ? byteCnt - 8'd1 : 8'd0;
            Tx_RdBuff <= (byteCnt > 8'd1);
          end else begin
            Tx     <= FLAG[bitCnt[2:0]];
            bitCnt <= bitCnt + 4'd1;
            if (bitCnt == 4'd6) Tx_RdBuff <= 1'b1;
          end
        end

        DATA: begin
          if (Tx_AbortFrame) begin
            state           <= ABORT;
            Tx              <= 1'b0;
            Tx_ValidFrame   <= 1'b0;
            Tx_AbortedTrans <= 1'b1;
            bitCnt          <= 4'd1;
          end else if (onesCnt == 3'd5) begin
            // Stuffed zero: the shifter holds its position for this cycle.
            Tx      <= 1'b0;
            onesCnt <= 3'd0;
          end else if (bitsLeft != 3'd0) begin
            Tx       <= shiftReg[0];
            shiftReg <= shiftReg >> 1;
            bitsLeft <= bitsLeft - 3'd1;
            onesCnt  <= shiftReg[0] ? onesCnt + 3'd1 : 3'd0;
          end else if (byteCnt != 8'd0) begin
            Tx        <= loadByte[0];
            shiftReg  <= loadByte >> 1;
            bitsLeft  <= 3'd7;
            onesCnt   <= loadByte[0] ? onesCnt + 3'd1 : 3'd0;
            byteCnt   <= byteCnt - 8'd1;
            Tx_RdBuff <= (byteCnt > 8'd1);
          end else begin
            state         <= END_FLAG;
            Tx            <= FLAG[0];
            Tx_ValidFrame <= 1'b0;
            bitCnt        <= 4'd1;
          end
        end

        END_FLAG: begin
          if (bitCnt == 4'd8) begin
            state   <= IDLE;
            Tx      <= 1'b1;
            Tx_Done <= 1'b1;
          end else begin
            Tx     <= FLAG[bitCnt[2:0]];
            bitCnt <= bitCnt + 4'd1;
          end
        end

        ABORT: begin
          Tx <= 1'b1;
          if (bitCnt == 4'd8) state <= IDLE;
          else bitCnt <= bitCnt + 4'd1;
        end

        default: begin
          state <= IDLE;
          Tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
